// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types, default widths and helpers for the SRAM arbiter.
//   onehot()    : 3-bit index -> 8-bit one-hot vector
//   first_set() : lowest set bit of an 8-bit request vector (fixed priority)
//   rr_next()   : round-robin scan starting after a given index
package sram_arb_pkg;

  localparam int MAX_REQ      = 8;
  localparam int DEF_N_REQ    = 4;
  localparam int DEF_IDX_W    = 2;
  localparam int DEF_ADDR_W   = 15;
  localparam int DEF_MAX_HOLD = 16;
  localparam int DEF_PARK     = 1;

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

  function automatic logic [2:0] first_set(input logic [7:0] reqv);
    logic [2:0] r;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (reqv[3'(k)]) r = 3'(k);
    end
    return r;
  endfunction

  // Scans idx+1, idx+2, ... modulo n; idx itself is visited last, so the
  // previous owner only wins when nobody else is asking.
  function automatic rr_pick_t rr_next(input logic [2:0] idx,
                                       input logic [7:0] reqv,
                                       input int         n);
    rr_pick_t p;
    int       j;
    p = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n && !p.found) begin
        j = (int'(idx) + k) % n;
        if (reqv[3'(j)]) begin
          p.found = 1'b1;
          p.idx   = 3'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sram_arb_mux.sv
// sram_arb_mux: routes the current owner's flattened SRAM control bus onto the
// physical RAM port. Chip select and write enables are gated by owner_vld so a
// requester without a valid grant can never touch the RAM.
//   owner, owner_vld        : registered owner from the arbiter
//   m_cs/m_asel/m_a0/m_a1   : per-requester control and addresses (flattened)
//   m_we0/m_we1             : per-requester byte write enables (flattened)
//   ram_*                   : physical SRAM port
module sram_arb_mux
  import sram_arb_pkg::*;
#(
  parameter int g_n_req      = DEF_N_REQ,
  parameter int g_idx_width  = DEF_IDX_W,
  parameter int g_word_width = DEF_ADDR_W - 3
) (
  input  logic [g_idx_width-1:0]          owner,
  input  logic                            owner_vld,
  input  logic [g_n_req-1:0]              m_cs,
  input  logic [g_n_req-1:0]              m_asel,
  input  logic [g_n_req*g_word_width-1:0] m_a0,
  input  logic [g_n_req*g_word_width-1:0] m_a1,
  input  logic [g_n_req*8-1:0]            m_we0,
  input  logic [g_n_req*8-1:0]            m_we1,
  output logic                            ram_cs,
  output logic                            ram_asel,
  output logic [g_word_width-1:0]         ram_a0,
  output logic [g_word_width-1:0]         ram_a1,
  output logic [7:0]                      ram_we0,
  output logic [7:0]                      ram_we1
);

  logic       sel_cs;
  logic [7:0] sel_we0;
  logic [7:0] sel_we1;

  // Compare-and-select instead of a variable part-select keeps widths exact
  // and guarantees owner values >= g_n_req select nothing.
  always_comb begin
    sel_cs   = 1'b0;
    sel_we0  = '0;
    sel_we1  = '0;
    ram_asel = 1'b0;
    ram_a0   = '0;
    ram_a1   = '0;
    for (int i = 0; i < g_n_req; i++) begin
      if (owner == g_idx_width'(i)) begin
        sel_cs   = m_cs[i];
        ram_asel = m_asel[i];
        ram_a0   = m_a0[i*g_word_width +: g_word_width];
        ram_a1   = m_a1[i*g_word_width +: g_word_width];
        sel_we0  = m_we0[i*8 +: 8];
        sel_we1  = m_we1[i*8 +: 8];
      end
    end
    ram_cs  = owner_vld & sel_cs;
    ram_we0 = owner_vld ? sel_we0 : 8'h00;
    ram_we1 = owner_vld ? sel_we1 : 8'h00;
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM macro between g_n_req bus2ram-style requesters.
//   clk, rst_n            : clock, asynchronous active-low reset
//   cfg_fixed_prio        : 1 = fixed priority (index 0 highest), 0 = round-robin
//   req / gnt             : per-requester request, registered one-hot grant
//   m_*                   : per-requester flattened RAM control buses
//   ram_*                 : physical RAM port (combinational on registered owner)
//   owner                 : registered owner index
//   rd_valid / rd_owner   : read-data valid and the requester it belongs to
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int g_n_req      = DEF_N_REQ,
  parameter int g_idx_width  = DEF_IDX_W,
  parameter int g_addr_width = DEF_ADDR_W,
  parameter int g_max_hold   = DEF_MAX_HOLD,
  parameter int g_park       = DEF_PARK
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_fixed_prio,
  input  logic [g_n_req-1:0]                  req,
  output logic [g_n_req-1:0]                  gnt,
  input  logic [g_n_req-1:0]                  m_cs,
  input  logic [g_n_req-1:0]                  m_asel,
  input  logic [g_n_req*(g_addr_width-3)-1:0] m_a0,
  input  logic [g_n_req*(g_addr_width-3)-1:0] m_a1,
  input  logic [g_n_req*8-1:0]                m_we0,
  input  logic [g_n_req*8-1:0]                m_we1,
  output logic                                ram_cs,
  output logic                                ram_asel,
  output logic [g_addr_width-4:0]             ram_a0,
  output logic [g_addr_width-4:0]             ram_a1,
  output logic [7:0]                          ram_we0,
  output logic [7:0]                          ram_we1,
  output logic [g_idx_width-1:0]              owner,
  output logic                                rd_valid,
  output logic [g_idx_width-1:0]              rd_owner
);

  localparam int WORD_W   = g_addr_width - 3;
  localparam int HOLD_W   = (g_max_hold < 2) ? 1 : $clog2(g_max_hold);
  localparam int HOLD_LIM = (g_max_hold == 0) ? 0 : g_max_hold - 1;

  arb_state_t        state;
  logic              owner_vld;
  logic [HOLD_W-1:0] hold_cnt;

  logic [7:0]         req_ext;
  logic [2:0]         owner_ext;
  logic               others;
  logic               at_limit;
  logic               keep;
  rr_pick_t           rr;
  logic [2:0]         pick_idx;
  logic               pick_found;
  logic [g_n_req-1:0] gnt_next;

  assign owner_vld = (state == ST_OWNED);

  // Decision logic: keep the current owner unless it dropped req or has used
  // up its hold budget while someone else waits; otherwise pick a new owner.
  always_comb begin
    req_ext                = '0;
    req_ext[g_n_req-1:0]   = req;
    owner_ext              = 3'(owner);
    others   = |(req_ext & ~onehot(owner_ext));
    at_limit = (g_max_hold != 0) && (hold_cnt == HOLD_W'(HOLD_LIM));
    keep     = owner_vld & req_ext[owner_ext] & ~(at_limit & others);
    rr       = rr_next(owner_ext, req_ext, g_n_req);
    if (cfg_fixed_prio) begin
      pick_idx   = first_set(req_ext);
      pick_found = |req_ext;
    end else begin
      pick_idx   = rr.idx;
      pick_found = rr.found;
    end
    gnt_next = '0;
    for (int i = 0; i < g_n_req; i++) begin
      gnt_next[i] = (pick_idx == 3'(i));
    end
  end

  // A re-pick (even of the same owner in fixed mode) restarts the hold count;
  // parking leaves everything, including hold_cnt, untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= '0;
      gnt      <= '0;
      hold_cnt <= '0;
      rd_valid <= 1'b0;
      rd_owner <= '0;
    end else begin
      rd_valid <= ram_cs & ~|(ram_asel ? ram_we1 : ram_we0);
      rd_owner <= owner;
      if (keep) begin
        if (hold_cnt != HOLD_W'(HOLD_LIM)) hold_cnt <= hold_cnt + 1'b1;
      end else if (pick_found) begin
        state    <= ST_OWNED;
        owner    <= g_idx_width'(pick_idx);
        gnt      <= gnt_next;
        hold_cnt <= '0;
      end else if (!((g_park != 0) && owner_vld)) begin
        state    <= ST_IDLE;
        gnt      <= '0;
        hold_cnt <= '0;
      end
    end
  end

  sram_arb_mux #(
    .g_n_req      (g_n_req),
    .g_idx_width  (g_idx_width),
    .g_word_width (WORD_W)
  ) u_mux (
    .owner     (owner),
    .owner_vld (owner_vld),
    .m_cs      (m_cs),
    .m_asel    (m_asel),
    .m_a0      (m_a0),
    .m_a1      (m_a1),
    .m_we0     (m_we0),
    .m_we1     (m_we1),
    .ram_cs    (ram_cs),
    .ram_asel  (ram_asel),
    .ram_a0    (ram_a0),
    .ram_a1    (ram_a1),
    .ram_we0   (ram_we0),
    .ram_we1   (ram_we1)
  );

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one physical SRAM between g_n_req bus2ram-style requesters.
- Arbitrates their req lines and returns a registered one-hot gnt.
- Muxes the owner's SRAM control, address and write-enable onto the physical RAM port, and tags the following read-data cycle with the owner index.
- Sits between the per-bus RAM bridges and the shared SRAM macro in the MAC memory subsystem.

Parameters:
- g_n_req, 4: number of requesters (2..8).
- g_idx_width, 2: owner index width; must satisfy 2**g_idx_width >= g_n_req.
- g_addr_width, 15: byte address width; RAM word address is g_addr_width-3 bits.
- g_max_hold, 16: max consecutive cycles one owner keeps the grant while others wait; 0 = unlimited.
- g_park, 1: 1 = grant stays with the last owner when no requests are pending; 0 = grant drops to all-zero.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_fixed_prio  in  1  1 = fixed priority (index 0 highest); 0 = round-robin
- req  in  g_n_req  per-requester access request
- gnt  out  g_n_req  registered one-hot grant
- m_cs  in  g_n_req  per-requester RAM chip select
- m_asel  in  g_n_req  per-requester address select (0 = a0/we0, 1 = a1/we1)
- m_a0  in  g_n_req*(g_addr_width-3)  flattened a0 addresses; requester i at slice i
- m_a1  in  g_n_req*(g_addr_width-3)  flattened a1 addresses
- m_we0  in  g_n_req*8  flattened byte write enables, lane 0 path
- m_we1  in  g_n_req*8  flattened byte write enables, lane 1 path
- ram_cs  out  1  physical RAM chip select
- ram_asel  out  1  physical address select
- ram_a0  out  g_addr_width-3  physical a0
- ram_a1  out  g_addr_width-3  physical a1
- ram_we0  out  8  physical we0
- ram_we1  out  8  physical we1
- owner  out  g_idx_width  current owner index (registered)
- rd_valid  out  1  RAM read data valid this cycle
- rd_owner  out  g_idx_width  requester that owns the current read data

Behaviour:
- Reset values: gnt=0, owner=0, owner_vld=0, hold_cnt=0, rd_valid=0, rd_owner=0. Combinational outputs follow: ram_cs=0, ram_we0=0, ram_we1=0.
- Arbitration is evaluated every cycle; gnt/owner update on the next clk edge. Latency from req rising to gnt is 1 cycle; the requester holds its access internally until gnt is seen.
- Keep rule: owner_vld & req[owner] & ~(g_max_hold!=0 & hold_cnt==g_max_hold-1 & |(req & ~onehot(owner))) -> gnt unchanged.
- Otherwise, select among pending requests:
  - Fixed mode: lowest index with req=1.
  - Round-robin: first req=1 scanning owner+1, owner+2, ... modulo g_n_req, with wrap-around. The old owner is eligible last, so it is re-granted only if it is the sole requester.
- No request pending: g_park=1 with owner_vld=1 keeps gnt and owner. Otherwise gnt=0 and owner_vld=0, and owner keeps its value.
- Handover: the owner dropping req while others request switches gnt in the next cycle with no idle bubble. A preempted owner loses gnt immediately; its bridge stays in hold and re-requests.
- hold_cnt:
  - clears on any owner change or grant loss;
  - increments, saturating at g_max_hold-1, while the owner is kept with req high;
  - holds its value while parked.
- Datapath mux, combinational on the registered owner:
  - ram_cs = owner_vld & m_cs[owner]
  - ram_asel = m_asel[owner]
  - ram_a0/ram_a1 = owner slices, ungated
  - ram_we0/ram_we1 = owner slices when owner_vld, else 0
- Non-owner inputs are ignored completely.
- Read tagging: rd_valid <= ram_cs & ~|(ram_asel ? ram_we1 : ram_we0); rd_owner <= owner. This matches the 1-cycle SRAM read latency.
- cfg_fixed_prio is sampled at each arbitration decision; changing it never revokes a kept grant.
- req bits at index >= g_n_req do not exist. owner never exceeds g_n_req-1.
- Reset mid-access: all grants and write enables drop asynchronously; no partial write is issued after reset assertion.

Decomposition:
- Shared package sram_arb_pkg holds:
  - default widths;
  - the onehot function;
  - a round-robin next-index function: index, req vector -> index + found flag.
- One natural sub-module is sram_arb_mux, the owner-indexed flattened-bus mux and gating. The grant FSM and counters stay in the top.

Test Plan:
- Single requester (req[1]=1 from cycle 2) -> gnt=4'b0010 at cycle 3, owner=1, ram_cs follows m_cs[1]. Parked after req drops (g_park=1): gnt stays 0010.
- req=4'b1111 held, round-robin, g_max_hold=4, owner=0 -> grant sequence 0,1,2,3,0 with 4 cycles each, no bubble cycles.
- Same stimulus with cfg_fixed_prio=1 and g_max_hold=0 -> gnt stays 0001 indefinitely. Dropping req[0] -> gnt=0010 next cycle.
- Owner 2 writes m_we0=8'h0F while requester 3 drives m_we0=8'hFF -> ram_we0=8'h0F only, and rd_valid=0 next cycle.
- Owner 1 read (m_cs=1, we=0) at cycle N -> rd_valid=1, rd_owner=1 at cycle N+1, even if gnt switches to requester 3 at N+1.
- Assert rst_n low mid-burst with owner 2 writing -> ram_we0=ram_we1=0 and gnt=0 immediately. After release, the first grant needs a fresh req and arrives 1 cycle after it.
